// File: rtl/genesis_pad_reader.sv
// genesis_pad_reader: scans one 3-button Genesis-style joypad port.
// Toggles pad_sel once per scan period, samples the six multiplexed active-low
// pins through a 2-flop synchronizer and publishes an active-high button word,
// a pad-present flag and a one-cycle update strobe.
// Optional feature: define GENESIS_PAD_DEBOUNCE_EN to hold the outputs until the
// scanned word has been identical for Stable consecutive scans.
module genesis_pad_reader #(
    parameter int unsigned Clock  = 50000000,
    parameter int unsigned ScanHz = 1000,
    parameter int unsigned Settle = 8,
    parameter int unsigned Stable = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pad_up,
    input  logic       pad_down,
    input  logic       pad_left,
    input  logic       pad_right,
    input  logic       pad_a_b,
    input  logic       pad_c_s,
    output logic       pad_sel,
    output logic [7:0] buttons,
    output logic       present,
    output logic       update
);

    localparam int unsigned Period = Clock / ScanHz;
    localparam int unsigned TickW  = $clog2(Period);
    localparam int unsigned SetW   = $clog2(Settle);
    localparam int unsigned PinW   = 6;

    // Pin positions inside the synchronized pin vector.
    localparam int unsigned PinUp    = 0;
    localparam int unsigned PinDown  = 1;
    localparam int unsigned PinLeft  = 2;
    localparam int unsigned PinRight = 3;
    localparam int unsigned PinAB    = 4;
    localparam int unsigned PinCS    = 5;

    // Reject parameter sets the scan sequence cannot honour.
    if (Period < 16 || Settle < 3 || Stable < 1) begin : g_param_check
        $error("genesis_pad_reader: need Clock/ScanHz >= 16, Settle >= 3, Stable >= 1");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SETTLE_HI = 2'd1,
        DRIVE_LO  = 2'd2,
        PUBLISH   = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [TickW-1:0]   tick_cnt;
    logic               tick_c;
    logic [SetW-1:0]    settle_cnt;
    logic               settle_done_c;
    logic [PinW-1:0]    pins_raw;
    logic [PinW-1:0]    sync_1;
    logic [PinW-1:0]    sync_2;
    logic [PinW-1:0]    hi;
    logic               sel_next_c;
    logic               publish_c;
    logic               cand_present_c;
    logic [7:0]         cand_buttons_c;
    logic               take_c;

    assign pins_raw = {pad_c_s, pad_a_b, pad_right, pad_left, pad_down, pad_up};

    // Two-flop synchronizer; idles high like an unplugged, pulled-up port.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_1 <= '1;
            sync_2 <= '1;
        end else begin
            sync_1 <= pins_raw;
            sync_2 <= sync_1;
        end
    end

    // Free-running scan period counter, 0..Period-1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick_c) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TickW'(1);
        end
    end

    assign tick_c        = (tick_cnt == TickW'(Period - 1));
    assign settle_done_c = (settle_cnt == SetW'(Settle - 1));

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic; ticks outside IDLE are dropped.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (tick_c) next_state = SETTLE_HI;
            SETTLE_HI: if (settle_done_c) next_state = DRIVE_LO;
            DRIVE_LO:  if (settle_done_c) next_state = PUBLISH;
            PUBLISH:   next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // FSM output decode; pad_sel is low exactly while in DRIVE_LO.
    always_comb begin
        sel_next_c = 1'b1;
        publish_c  = 1'b0;
        if (next_state == DRIVE_LO) begin
            sel_next_c = 1'b0;
        end
        if (state == PUBLISH) begin
            publish_c = 1'b1;
        end
    end

    // Settle counter, cleared on every state change.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            settle_cnt <= '0;
        end else if (state != next_state) begin
            settle_cnt <= '0;
        end else if (state == SETTLE_HI || state == DRIVE_LO) begin
            settle_cnt <= settle_cnt + SetW'(1);
        end
    end

    // Latch the sel=1 half of the pad at the end of SETTLE_HI.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi <= '1;
        end else if (state == SETTLE_HI && settle_done_c) begin
            hi <= sync_2;
        end
    end

    // Candidate word. The sel=0 half is taken straight from the synchronizer in
    // PUBLISH: the synchronizer still lags the sel rise there, and the extra
    // cycle keeps a late pad response sampled correctly even at Settle=3.
    always_comb begin
        cand_present_c = ~sync_2[PinLeft] & ~sync_2[PinRight];
        cand_buttons_c = 8'h00;
        if (cand_present_c) begin
            cand_buttons_c = ~{sync_2[PinCS], sync_2[PinAB],
                               hi[PinCS], hi[PinAB], hi[PinRight],
                               hi[PinLeft], hi[PinDown], hi[PinUp]};
        end
    end

`ifdef GENESIS_PAD_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(Stable + 1);

    logic [8:0]      prev_cand;
    logic [CntW-1:0] match_cnt;
    logic [CntW-1:0] match_next_c;

    // Consecutive-match count including this scan, saturating at Stable.
    always_comb begin
        match_next_c = CntW'(1);
        if ({cand_present_c, cand_buttons_c} == prev_cand) begin
            match_next_c = (match_cnt == CntW'(Stable)) ? match_cnt
                                                        : match_cnt + CntW'(1);
        end
    end

    assign take_c = (match_next_c >= CntW'(Stable));

    // Remember the last candidate and its run length.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_cand <= '0;
            match_cnt <= '0;
        end else if (publish_c) begin
            prev_cand <= {cand_present_c, cand_buttons_c};
            match_cnt <= match_next_c;
        end
    end
`else
    assign take_c = 1'b1;
`endif

    // Registered outputs; buttons/present move only alongside update.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pad_sel <= 1'b1;
            buttons <= 8'h00;
            present <= 1'b0;
            update  <= 1'b0;
        end else begin
            pad_sel <= sel_next_c;
            update  <= publish_c;
            if (publish_c && take_c) begin
                buttons <= cand_buttons_c;
                present <= cand_present_c;
            end
        end
    end

endmodule

// File: tb/tb_genesis_pad_reader.sv
// tb_genesis_pad_reader: directed + randomized checks of genesis_pad_reader.
// Instance A: P=100, Settle=8, pad answers sel immediately.
// Instance B: P=20, Settle=3, pad answers one clock after every sel change.
`timescale 1ns/1ps
module tb_genesis_pad_reader;

    localparam int unsigned CLK_A = 1000;
    localparam int unsigned HZ_A  = 10;
    localparam int unsigned SET_A = 8;
    localparam int unsigned CLK_B = 1000;
    localparam int unsigned HZ_B  = 50;
    localparam int unsigned SET_B = 3;
`ifdef GENESIS_PAD_DEBOUNCE_EN
    localparam int unsigned STABLE = 3;
`else
    localparam int unsigned STABLE = 1;
`endif
    localparam int PER_A   = int'(CLK_A / HZ_A);
    localparam int PER_B   = int'(CLK_B / HZ_B);
    localparam int FIRST_A = PER_A - 1 + 2 * int'(SET_A) + 2;
    localparam int FIRST_B = PER_B - 1 + 2 * int'(SET_B) + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc;
    int         n_tests = 0;
    int         n_fail = 0;

    logic       plug_a = 1'b0;
    logic [7:0] press_a = 8'h00;
    logic       plug_b = 1'b0;
    logic [7:0] press_b = 8'h00;
    logic       sel_b_d = 1'b1;

    logic       a_u, a_d, a_l, a_r, a_ab, a_cs, sel_a, upd_a, pres_a;
    logic [7:0] btn_a;
    logic       b_u, b_d, b_l, b_r, b_ab, b_cs, sel_b, upd_b, pres_b;
    logic [7:0] btn_b;

    logic [8:0] hist_a[$];
    logic [8:0] hist_b[$];
    logic [8:0] exp_a = 9'h000;
    logic [8:0] exp_b = 9'h000;
    int         next_a;
    int         next_b;

    always #5 clk = ~clk;

    // Posedges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Pad B reacts to pad_sel one clock late.
    always @(posedge clk) sel_b_d <= sel_b;

    // 3-button pad pins {c_s,a_b,right,left,down,up}; press = {start,a,c,b,right,left,down,up}.
    function automatic logic [5:0] pad_pins(input logic plug, input logic [7:0] p, input logic sel);
        if (!plug) return 6'h3f;
        if (sel)   return ~{p[5], p[4], p[3], p[2], p[1], p[0]};
        return {~p[7], ~p[6], 1'b0, 1'b0, ~p[1], ~p[0]};
    endfunction

    always_comb {a_cs, a_ab, a_r, a_l, a_d, a_u} = pad_pins(plug_a, press_a, sel_a);
    always_comb {b_cs, b_ab, b_r, b_l, b_d, b_u} = pad_pins(plug_b, press_b, sel_b_d);

    genesis_pad_reader #(.Clock(CLK_A), .ScanHz(HZ_A), .Settle(SET_A), .Stable(3)) dut_a (
        .clock(clk), .reset(rst_n),
        .pad_up(a_u), .pad_down(a_d), .pad_left(a_l), .pad_right(a_r),
        .pad_a_b(a_ab), .pad_c_s(a_cs),
        .pad_sel(sel_a), .buttons(btn_a), .present(pres_a), .update(upd_a)
    );

    genesis_pad_reader #(.Clock(CLK_B), .ScanHz(HZ_B), .Settle(SET_B), .Stable(3)) dut_b (
        .clock(clk), .reset(rst_n),
        .pad_up(b_u), .pad_down(b_d), .pad_left(b_l), .pad_right(b_r),
        .pad_a_b(b_ab), .pad_c_s(b_cs),
        .pad_sel(sel_b), .buttons(btn_b), .present(pres_b), .update(upd_b)
    );

    // Expected {present, buttons} produced by one scan of a pad.
    function automatic logic [8:0] cand_of(input logic plug, input logic [7:0] p);
        return plug ? {1'b1, p} : 9'h000;
    endfunction

    // Outputs follow a scan only when the last STABLE scans since reset agree.
    task automatic model_a(input logic [8:0] cand);
        bit same;
        hist_a.push_back(cand);
        if (hist_a.size() > STABLE) void'(hist_a.pop_front());
        if (hist_a.size() == STABLE) begin
            same = 1'b1;
            foreach (hist_a[i]) if (hist_a[i] != cand) same = 1'b0;
            if (same) exp_a = cand;
        end
    endtask

    task automatic model_b(input logic [8:0] cand);
        bit same;
        hist_b.push_back(cand);
        if (hist_b.size() > STABLE) void'(hist_b.pop_front());
        if (hist_b.size() == STABLE) begin
            same = 1'b1;
            foreach (hist_b[i]) if (hist_b[i] != cand) same = 1'b0;
            if (same) exp_b = cand;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for an update strobe, counting pad_sel-low cycles on the way.
    task automatic wait_upd(input bit which, input int budget, output int at, output int lows, output bit ok);
        ok = 1'b0; lows = 0; at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which ? sel_b : sel_a) == 1'b0) lows++;
            if (which ? upd_b : upd_a) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic scan_a(input string tag);
        int at, lows;
        bit ok;
        wait_upd(1'b0, 400, at, lows, ok);
        check({tag, "_seen"}, 32'(ok), 32'd1);
        check({tag, "_cycle"}, 32'(at), 32'(next_a));
        check({tag, "_sel_low"}, 32'(lows), 32'(SET_A));
        model_a(cand_of(plug_a, press_a));
        check({tag, "_buttons"}, 32'(btn_a), 32'(exp_a[7:0]));
        check({tag, "_present"}, 32'(pres_a), 32'(exp_a[8]));
        next_a += PER_A;
        @(negedge clk);
        check({tag, "_upd_1cyc"}, 32'(upd_a), 32'd0);
    endtask

    task automatic scan_b(input string tag);
        int at, lows;
        bit ok;
        wait_upd(1'b1, 100, at, lows, ok);
        check({tag, "_seen"}, 32'(ok), 32'd1);
        check({tag, "_cycle"}, 32'(at), 32'(next_b));
        check({tag, "_sel_low"}, 32'(lows), 32'(SET_B));
        model_b(cand_of(plug_b, press_b));
        check({tag, "_buttons"}, 32'(btn_b), 32'(exp_b[7:0]));
        check({tag, "_present"}, 32'(pres_b), 32'(exp_b[8]));
        next_b += PER_B;
        @(negedge clk);
    endtask

    initial begin
        int  missed;
        bit  found;
        logic [7:0] pat;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_sel", 32'(sel_a), 32'd1);
        check("rst_buttons", 32'(btn_a), 32'd0);
        check("rst_present", 32'(pres_a), 32'd0);
        check("rst_update", 32'(upd_a), 32'd0);
        rst_n  = 1'b1;
        next_a = FIRST_A;

        // Unplugged pad: all pins pulled up.
        scan_a("nopad");

        // Directed patterns, each held long enough to pass any debounce.
        plug_a = 1'b1; press_a = 8'hC0;
        for (int k = 0; k < int'(STABLE); k++) scan_a("start_a");
        check("start_a_word", 32'(btn_a), 32'h0C0);
        press_a = 8'h21;
        for (int k = 0; k < int'(STABLE); k++) scan_a("up_c");
        check("up_c_word", 32'(btn_a), 32'h021);
        press_a = 8'h18;
        for (int k = 0; k < int'(STABLE); k++) scan_a("b_right");
        check("b_right_word", 32'(btn_a), 32'h018);

        // Random pads, new pattern every scan.
        for (int k = 0; k < 6; k++) begin
            plug_a  = ($urandom_range(0, 3) != 0);
            press_a = 8'($urandom);
            scan_a("rand");
        end

        // Start toggling each scan, then held.
        plug_a = 1'b1; press_a = 8'h00;
        for (int k = 0; k < int'(STABLE); k++) scan_a("idle_pad");
        for (int k = 0; k < 6; k++) begin
            press_a = (k % 2 == 0) ? 8'h80 : 8'h00;
            scan_a("toggle");
`ifdef GENESIS_PAD_DEBOUNCE_EN
            check("toggle_hold", 32'(btn_a), 32'h000);
`endif
        end
        press_a = 8'h80;
        for (int k = 0; k < 3; k++) begin
            scan_a("start_held");
`ifdef GENESIS_PAD_DEBOUNCE_EN
            check("start_held_deb", 32'(btn_a), (k == 2) ? 32'h080 : 32'h000);
`endif
        end
        check("start_held_final", 32'(btn_a), 32'h080);

        // Reset three cycles into DRIVE_LO.
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sel_a == 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check("drive_lo_seen", 32'(found), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_sel_low", 32'(sel_a), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_sel", 32'(sel_a), 32'd1);
        check("midrst_update", 32'(upd_a), 32'd0);
        check("midrst_buttons", 32'(btn_a), 32'd0);
        check("midrst_present", 32'(pres_a), 32'd0);
        hist_a.delete(); exp_a = 9'h000;
        hist_b.delete(); exp_b = 9'h000;
        plug_b = 1'b1; press_b = 8'($urandom);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        next_a = FIRST_A;
        scan_a("post_rst");

        // Instance B: Settle=3, pad answering one clock after each sel edge.
        next_b = FIRST_B;
        missed = 0;
        while (next_b <= cyc) begin
            next_b += PER_B;
            missed++;
        end
        for (int k = 0; k < missed; k++) model_b(cand_of(plug_b, press_b));
        scan_b("b_hold");
        for (int p = 0; p < 3; p++) begin
            pat     = 8'($urandom);
            press_b = pat;
            for (int k = 0; k < int'(STABLE); k++) scan_b("b_late");
        end
        check("b_last_word", 32'(btn_b), 32'(pat));
        check("b_last_present", 32'(pres_b), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
